// File: rtl/deser182.sv
// Serial-to-parallel collector: steers each accepted bit into slot idx (LSB first)
// and presents the assembled N-bit word on a valid/ready output port.
module deser182 #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_bit,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] idx
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   buffer;
    logic [N-1:0]   buf_next;
    logic           accept;

    assign in_ready = !out_valid;
    assign accept   = in_valid && in_ready;

    // Buffer with the incoming bit merged in; the last slot is only ever filled here.
    always_comb begin
        buf_next      = buffer;
        buf_next[idx] = in_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            buffer    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= COLLECT;
            idx       <= '0;
            buffer    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (idx == IDXW'(N - 1)) begin
                            out_data  <= buf_next;
                            out_valid <= 1'b1;
                            idx       <= '0;
                            buffer    <= '0;
                            state     <= HOLD;
                        end else begin
                            buffer <= buf_next;
                            idx    <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_deser182.sv
// Randomized + directed bench for deser182: a word-level model feeds a scoreboard
// and a per-cycle status queue; an independent monitor pops and compares both.
module tb_deser182;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_bit;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   idx;

    deser182 #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .idx      (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           pend;
        int           cnt;
        logic [N-1:0] dout;
        bit           chk_out;
    } status_t;

    logic [N-1:0] sb[$];
    status_t      stq[$];
    int           hs_cyc[$];

    // model state (stimulus side only)
    bit           m_pend;
    int           m_cnt;
    logic [N-1:0] m_word;
    logic [N-1:0] m_out;
    int           m_xfers;
    int           bb_idx;
    int           timeouts;
    bit           done;

    // monitor side only
    int total;
    int bad;
    int mon_xfers;
    int cycle;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic cyc(input logic r, input logic f, input logic v, input logic b, input logic o);
        bit chk;
        rst_n = r; flush = f; in_valid = v; in_bit = b; out_ready = o;
        chk = 1'b0;
        if (!r) begin
            if (m_pend) void'(sb.pop_back());
            m_pend = 0; m_cnt = 0; m_word = '0; m_out = '0; chk = 1'b1;
        end else if (f) begin
            if (m_pend) void'(sb.pop_back());
            m_pend = 0; m_cnt = 0; m_word = '0;
        end else if (m_pend) begin
            if (o) begin
                m_pend = 0;
                m_xfers++;
            end
            chk = m_pend;
        end else begin
            if (v) begin
                m_word[m_cnt] = b;
                m_cnt++;
                if (m_cnt == N) begin
                    sb.push_back(m_word);
                    m_out  = m_word;
                    m_pend = 1;
                    m_cnt  = 0;
                    m_word = '0;
                end
            end
            chk = m_pend;
        end
        @(posedge clk);
        stq.push_back('{pend: m_pend, cnt: m_cnt, dout: m_out, chk_out: chk});
        #1;
    endtask

    // Offers the word bit by bit, advancing only when the DUT was ready; bounded.
    task automatic send_word(input logic [N-1:0] w, input bit gaps, input logic o);
        int  i;
        bit  v;
        bit  acc;
        i = 0;
        for (int t = 0; t < 64 && i < N; t++) begin
            v   = gaps ? (t % 2 == 0) : 1'b1;
            acc = v && in_ready;
            cyc(1'b1, 1'b0, v, v ? w[i] : 1'($urandom), o);
            if (acc) i++;
        end
        if (i < N) timeouts++;
    endtask

    always @(negedge clk) begin
        status_t s;
        logic [N-1:0] e;
        if (stq.size() > 0) begin
            s = stq.pop_front();
            total += 3;
            if (out_valid !== s.pend) begin
                bad++; $display("FAIL out_valid got=%b exp=%b cyc=%0d", out_valid, s.pend, cycle);
            end
            if (in_ready !== !s.pend) begin
                bad++; $display("FAIL in_ready got=%b exp=%b cyc=%0d", in_ready, !s.pend, cycle);
            end
            if (idx !== 3'(s.cnt)) begin
                bad++; $display("FAIL idx got=%0d exp=%0d cyc=%0d", idx, s.cnt, cycle);
            end
            if (s.chk_out) begin
                total++;
                if (out_data !== s.dout) begin
                    bad++; $display("FAIL out_data_hold got=%h exp=%h cyc=%0d", out_data, s.dout, cycle);
                end
            end
        end
        if (rst_n && !flush && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL xfer_unexpected got=%h exp=none cyc=%0d", out_data, cycle);
            end else begin
                e = sb.pop_front();
                if (out_data !== e) begin
                    bad++; $display("FAIL xfer_data got=%h exp=%h cyc=%0d", out_data, e, cycle);
                end
            end
            mon_xfers++;
            hs_cyc.push_back(cycle);
        end
        if (done) begin
            total++;
            if (timeouts != 0) begin
                bad++; $display("FAIL send_timeout got=%0d exp=0", timeouts);
            end
            total++;
            if (mon_xfers != m_xfers) begin
                bad++; $display("FAIL xfer_count got=%0d exp=%0d", mon_xfers, m_xfers);
            end
            total++;
            if (sb.size() != 0) begin
                bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
            end
            total++;
            if (hs_cyc.size() < bb_idx + 2) begin
                bad++; $display("FAIL b2b_period got=missing exp=9");
            end else if (hs_cyc[bb_idx + 1] - hs_cyc[bb_idx] != 9) begin
                bad++; $display("FAIL b2b_period got=%0d exp=9", hs_cyc[bb_idx + 1] - hs_cyc[bb_idx]);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        total = 0; bad = 0; mon_xfers = 0; cycle = 0;
        m_pend = 0; m_cnt = 0; m_word = '0; m_out = '0; m_xfers = 0;
        bb_idx = 0; timeouts = 0; done = 0;
        rst_n = 0; flush = 0; in_bit = 0; in_valid = 0; out_ready = 0;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        send_word(8'hA5, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h3C, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // held-off bits while the 0xFF word waits must not count
        send_word(8'hFF, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send_word(8'h5A, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_word(8'h01, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_word(8'hC3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        bb_idx = m_xfers;
        send_word(8'h12, 1'b0, 1'b1);
        send_word(8'h34, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        send_word(8'h77, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(99) != 0), 1'($urandom_range(29) == 0),
                1'($urandom), 1'($urandom), 1'($urandom_range(3) != 0));
        end

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        done = 1;
    end

endmodule

// File: doc/deser182.md
# deser182

Serial-to-parallel collector that reverses an 8:1 bit-select mux: each accepted serial bit is steered into the buffer slot addressed by an internal index counter (index 0 → bit 0). After N bits it presents the assembled word on a valid/ready output port. It sits at the receive end of any serializer that walks its select from 0 to N-1, LSB first.

## Interface
- N, default 8, word width in bits; power of two, ≥ 2
- IDXW, default $clog2(N), index counter width; derived, not overridden
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- flush  input  1  synchronous abort; discards the partial word and any pending word
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  block can accept a bit this cycle
- out_data  output  N  assembled word, bit i = i-th accepted bit
- out_valid  output  1  out_data holds a complete word
- out_ready  input  1  downstream accepts out_data this cycle
- idx  output  IDXW  slot the next accepted bit will be written to (debug/status)

## Operation
- Reset (rst_n=0 at a clock edge): state=COLLECT, idx=0, internal buffer=0, out_data=0, out_valid=0. in_ready=1 after the reset edge. Reset overrides all other inputs.
- The accept event is in_valid && in_ready.
- in_ready = !out_valid (combinational from registered out_valid).
- State COLLECT:
  - On accept, buffer[idx] <= in_bit. Idx increments modulo N.
  - If idx == N-1 on accept:
    - out_data <= buffer with bit N-1 replaced by in_bit.
    - out_valid <= 1, idx <= 0, buffer <= 0.
    - Go to HOLD.
  - Cycles with in_valid=0 leave all state unchanged. Gaps between bits are allowed.
- State HOLD:
  - out_data and out_valid are stable. in_ready=0, so in_bit and in_valid are ignored.
  - On out_ready=1: out_valid <= 0, go to COLLECT. out_data keeps its last value; it is don't-care while out_valid=0.
  - out_ready during COLLECT has no effect.
- flush=1 (rst_n=1): idx <= 0, buffer <= 0, out_valid <= 0, state <= COLLECT.
  - A bit offered in the same cycle is dropped.
  - A pending word is lost even if out_ready=1 in that cycle; the verifier counts no transfer.
  - out_data is not cleared.
- Priority: rst_n > flush > out_ready handshake > bit accept.
- No width arithmetic beyond the modulo-N idx increment. idx wraps N-1 → 0 only on word completion.

## Timing
- Latency: the word is visible (out_valid=1) immediately after the clock edge that accepts the N-th bit.
- Minimum word period is N+1 cycles: N accept cycles plus ≥ 1 HOLD cycle. No bit is accepted in the cycle out_ready completes the handshake; in_ready rises after that edge.
- out_valid, once high, stays high and out_data stays constant until a handshake edge, flush or reset.
- idx is registered and reflects the state after the last edge.
- All outputs are glitch-free registers except in_ready, which is an inverter on out_valid.

## Test plan
- Reset then send 0xA5 LSB first (bits 1,0,1,0,0,1,0,1) with continuous in_valid and out_ready=1 → out_valid=1 with out_data=0xA5 one edge after the 8th accept. in_ready=0 for exactly one cycle. idx reads 0 afterwards.
- Send 0x3C with in_valid toggling 1,0 every cycle → out_data=0x3C after 15 cycles. idx holds its value across every gap cycle.
- Complete 0xFF with out_ready held 0 for 5 cycles while in_valid=1 and in_bit=0 → out_data stays 0xFF and in_ready=0 throughout. After out_ready=1, the next word starts at idx=0 and the held-off bits are not counted.
- Send 3 bits of 1, assert flush, then send 0x01 → out_data=0x01, not 0x07. idx=0 after the flush edge.
- Assert rst_n=0 mid-word (idx=5) and also with out_valid=1 → all outputs return to reset values on that edge. in_ready=1 afterwards.
- Send back-to-back 0x12 then 0x34, with out_ready=1 throughout → two transfers in order with a 9-cycle period. Flush in the same cycle as out_ready in HOLD → out_valid=0 and no transfer is recorded.
